// File: rtl/loader_pkg.sv
// Shared types and constants for the program memory loader.
// The FSM state encoding, error codes and frame defaults live here.
package loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        LEN,
        DATA,
        CHK,
        DONE,
        ERR
    } state_t;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_CHK     = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

    localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

    // A length byte of zero encodes a full 256-byte frame.
    function automatic logic [8:0] frame_len(input logic [7:0] len_byte);
        return (len_byte == 8'd0) ? 9'd256 : {1'b0, len_byte};
    endfunction

endpackage

// File: rtl/loader_watchdog.sv
// Idle-cycle watchdog: counts enabled cycles since the last clear and
// flags expiry once the count sits at LIMIT-1.
module loader_watchdog #(
    parameter int unsigned LIMIT = 1024
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int W = (LIMIT > 1) ? $clog2(LIMIT) : 1;
    localparam logic [W-1:0] LAST = W'(LIMIT - 1);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Saturate at LAST so a held-off expiry never wraps back to zero.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && (count_q != LAST)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = enable && (count_q == LAST);

endmodule

// File: rtl/program_loader.sv
// Framed byte-stream loader: parses SYNC/LEN/payload/checksum frames,
// writes payload bytes into program memory and holds the CPU until a good frame lands.
module program_loader
    import loader_pkg::*;
#(
    parameter logic [7:0]  SYNC_BYTE      = DEFAULT_SYNC_BYTE,
    parameter logic [7:0]  BASE_ADDR      = 8'h00,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    output logic       rx_ready,
    output logic       pm_we,
    output logic [7:0] pm_addr,
    output logic [7:0] pm_wdata,
    output logic       cpu_hold,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic [1:0] err_code,
    output logic [8:0] words_written
);

    state_t     state_q,    state_d;
    logic [8:0] count_q,    count_d;
    logic [8:0] index_q,    index_d;
    logic [7:0] sum_q,      sum_d;
    logic       pm_we_q,    pm_we_d;
    logic [7:0] pm_addr_q,  pm_addr_d;
    logic [7:0] pm_wdata_q, pm_wdata_d;
    logic       cpu_hold_q, cpu_hold_d;
    logic       busy_q,     busy_d;
    logic       done_q,     done_d;
    logic       error_q,    error_d;
    logic [1:0] err_code_q, err_code_d;
    logic [8:0] words_q,    words_d;

    logic       accept;
    logic       wd_enable;
    logic       wd_expired;
    logic       timeout;
    logic [8:0] index_inc;
    logic [7:0] chk_total;

    assign rx_ready  = (state_q == HDR) || (state_q == LEN) ||
                       (state_q == DATA) || (state_q == CHK);
    assign accept    = rx_valid && rx_ready;
    assign wd_enable = (state_q == LEN) || (state_q == DATA) || (state_q == CHK);
    // An acceptance on the expiry cycle wins over the timeout.
    assign timeout   = wd_expired && !accept;
    assign index_inc = index_q + 9'd1;
    assign chk_total = sum_q + rx_data;

    loader_watchdog #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk     (clk),
        .reset   (reset),
        .clear   (accept || !wd_enable),
        .enable  (wd_enable),
        .expired (wd_expired)
    );

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        index_d    = index_q;
        sum_d      = sum_q;
        pm_we_d    = 1'b0;
        pm_addr_d  = pm_addr_q;
        pm_wdata_d = pm_wdata_q;
        cpu_hold_d = cpu_hold_q;
        busy_d     = busy_q;
        done_d     = done_q;
        error_d    = error_q;
        err_code_d = err_code_q;
        words_d    = words_q;

        case (state_q)
            IDLE, DONE, ERR: begin
                if (start) begin
                    state_d    = HDR;
                    cpu_hold_d = 1'b1;
                    busy_d     = 1'b1;
                    done_d     = 1'b0;
                    error_d    = 1'b0;
                    err_code_d = ERR_NONE;
                    words_d    = 9'd0;
                    sum_d      = 8'd0;
                end
            end
            HDR: begin
                if (accept && (rx_data == SYNC_BYTE)) begin
                    state_d = LEN;
                end
            end
            LEN: begin
                if (accept) begin
                    count_d = frame_len(rx_data);
                    index_d = 9'd0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (accept) begin
                    pm_we_d    = 1'b1;
                    pm_addr_d  = BASE_ADDR + index_q[7:0];
                    pm_wdata_d = rx_data;
                    sum_d      = chk_total;
                    index_d    = index_inc;
                    words_d    = words_q + 9'd1;
                    if (index_inc == count_q) begin
                        state_d = CHK;
                    end
                end
            end
            CHK: begin
                if (accept) begin
                    busy_d = 1'b0;
                    if (chk_total == 8'd0) begin
                        state_d    = DONE;
                        done_d     = 1'b1;
                        cpu_hold_d = 1'b0;
                    end else begin
                        state_d    = ERR;
                        error_d    = 1'b1;
                        err_code_d = ERR_CHK;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (timeout) begin
            state_d    = ERR;
            error_d    = 1'b1;
            err_code_d = ERR_TIMEOUT;
            busy_d     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            count_q    <= 9'd0;
            index_q    <= 9'd0;
            sum_q      <= 8'd0;
            pm_we_q    <= 1'b0;
            pm_addr_q  <= 8'd0;
            pm_wdata_q <= 8'd0;
            cpu_hold_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            err_code_q <= ERR_NONE;
            words_q    <= 9'd0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            index_q    <= index_d;
            sum_q      <= sum_d;
            pm_we_q    <= pm_we_d;
            pm_addr_q  <= pm_addr_d;
            pm_wdata_q <= pm_wdata_d;
            cpu_hold_q <= cpu_hold_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            error_q    <= error_d;
            err_code_q <= err_code_d;
            words_q    <= words_d;
        end
    end

    assign pm_we         = pm_we_q;
    assign pm_addr       = pm_addr_q;
    assign pm_wdata      = pm_wdata_q;
    assign cpu_hold      = cpu_hold_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign error         = error_q;
    assign err_code      = err_code_q;
    assign words_written = words_q;

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: two instances (base 00 and FE) share one stimulus stream
// and are checked against a frame-level reference model.
module tb_program_loader;

    localparam logic [7:0] BASE_A = 8'h00;
    localparam logic [7:0] BASE_B = 8'hFE;

    localparam logic [5:0] ST_BUSY    = 6'b000011;
    localparam logic [5:0] ST_OK      = 6'b100000;
    localparam logic [5:0] ST_BADCHK  = 6'b010110;
    localparam logic [5:0] ST_TIMEOUT = 6'b011010;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_data = 8'h00;

    logic       rx_ready_a, pm_we_a, cpu_hold_a, busy_a, done_a, error_a;
    logic [7:0] pm_addr_a, pm_wdata_a;
    logic [1:0] err_code_a;
    logic [8:0] words_a;
    logic       rx_ready_b, pm_we_b, cpu_hold_b, busy_b, done_b, error_b;
    logic [7:0] pm_addr_b, pm_wdata_b;
    logic [1:0] err_code_b;
    logic [8:0] words_b;

    program_loader #(.BASE_ADDR(BASE_A)) dut_a (
        .clk(clk), .reset(reset), .start(start), .rx_valid(rx_valid), .rx_data(rx_data),
        .rx_ready(rx_ready_a), .pm_we(pm_we_a), .pm_addr(pm_addr_a), .pm_wdata(pm_wdata_a),
        .cpu_hold(cpu_hold_a), .busy(busy_a), .done(done_a), .error(error_a),
        .err_code(err_code_a), .words_written(words_a)
    );

    program_loader #(.BASE_ADDR(BASE_B)) dut_b (
        .clk(clk), .reset(reset), .start(start), .rx_valid(rx_valid), .rx_data(rx_data),
        .rx_ready(rx_ready_b), .pm_we(pm_we_b), .pm_addr(pm_addr_b), .pm_wdata(pm_wdata_b),
        .cpu_hold(cpu_hold_b), .busy(busy_b), .done(done_b), .error(error_b),
        .err_code(err_code_b), .words_written(words_b)
    );

    always #5 clk = ~clk;

    logic [5:0]  st_a, st_b;
    logic [32:0] out_a, out_b;
    assign st_a  = {done_a, error_a, err_code_a, cpu_hold_a, busy_a};
    assign st_b  = {done_b, error_b, err_code_b, cpu_hold_b, busy_b};
    assign out_a = {rx_ready_a, pm_we_a, pm_addr_a, pm_wdata_a, st_a, words_a};
    assign out_b = {rx_ready_b, pm_we_b, pm_addr_b, pm_wdata_b, st_b, words_b};

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Write monitor: records every cycle on which either instance pulses pm_we.
    logic [33:0] obs_w [0:4095];
    int          obs_cyc [0:4095];
    int          obs_n = 0;
    int          rd_ptr = 0;
    always @(negedge clk) begin
        if ((pm_we_a || pm_we_b) && obs_n < 4096) begin
            obs_w[obs_n]   <= {pm_we_a, pm_addr_a, pm_wdata_a, pm_we_b, pm_addr_b, pm_wdata_b};
            obs_cyc[obs_n] <= cyc;
            obs_n          <= obs_n + 1;
        end
    end

    // Reference model state: payload of the current frame and the writes it must cause.
    logic [7:0]  pay_q [$];
    logic [33:0] exp_w [$];

    function automatic logic [7:0] good_chk();
        int s = 0;
        foreach (pay_q[i]) s += int'(pay_q[i]);
        return 8'((256 - (s % 256)) % 256);
    endfunction

    function automatic logic [5:0] exp_status(input logic [7:0] chk);
        int s = int'(chk);
        foreach (pay_q[i]) s += int'(pay_q[i]);
        return ((s % 256) == 0) ? ST_OK : ST_BADCHK;
    endfunction

    task automatic model_writes(input int n);
        for (int i = 0; i < n; i++)
            exp_w.push_back({1'b1, BASE_A + 8'(i), pay_q[i], 1'b1, BASE_B + 8'(i), pay_q[i]});
    endtask

    task automatic random_payload(input int n);
        pay_q.delete();
        for (int i = 0; i < n; i++) pay_q.push_back(8'($urandom));
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        logic acc;
        int   k;
        rx_valid = 1'b1;
        rx_data  = b;
        k = 0;
        do begin
            acc = rx_ready_a;
            tick(1);
            k++;
        end while (!acc && k < 2000);
        if (!acc) begin
            n_cmp++;
            n_fail++;
            $display("FAIL send_byte: byte %02h not accepted after %0d cycles, required acceptance", b, k);
        end
        rx_valid = 1'b0;
    endtask

    task automatic gap(input int gap_max);
        if (gap_max > 0) tick(int'($urandom_range(0, gap_max)));
    endtask

    task automatic send_frame(input logic [7:0] chk, input int gap_max);
        send_byte(8'hA5);
        gap(gap_max);
        send_byte((pay_q.size() == 256) ? 8'h00 : 8'(pay_q.size()));
        foreach (pay_q[i]) begin
            gap(gap_max);
            send_byte(pay_q[i]);
        end
        gap(gap_max);
        send_byte(chk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(3);
        n_cmp += 2;
        if (out_a !== 33'd0) begin n_fail++; $display("FAIL reset_a: outputs %09h, required 0", out_a); end
        if (out_b !== 33'd0) begin n_fail++; $display("FAIL reset_b: outputs %09h, required 0", out_b); end
        reset = 1'b0;
        tick(1);
        rd_ptr = obs_n;
        $display("reset: outputs a=%09h b=%09h", out_a, out_b);
    endtask

    task automatic test_frame_fixed(input string name, input logic [7:0] chk);
        logic [5:0] want;
        pay_q = '{8'hF3, 8'h12, 8'hC5};
        model_writes(3);
        want = exp_status(chk);
        pulse_start();
        n_cmp++;
        if (st_a !== ST_BUSY) begin n_fail++; $display("FAIL %s_start: status %06b, required %06b", name, st_a, ST_BUSY); end
        send_frame(chk, 0);
        n_cmp += 3;
        if (st_a !== want) begin n_fail++; $display("FAIL %s_status_a: %06b, required %06b", name, st_a, want); end
        if (st_b !== want) begin n_fail++; $display("FAIL %s_status_b: %06b, required %06b", name, st_b, want); end
        if (words_a !== 9'd3) begin n_fail++; $display("FAIL %s_words: %0d, required 3", name, words_a); end
        n_cmp++;
        if (obs_n - rd_ptr !== int'(exp_w.size())) begin n_fail++; $display("FAIL %s_nwrites: %0d, required %0d", name, obs_n - rd_ptr, exp_w.size()); end
        foreach (exp_w[i]) begin
            n_cmp++;
            if (obs_w[rd_ptr+i] !== exp_w[i]) begin n_fail++; $display("FAIL %s_write[%0d]: %09h, required %09h", name, i, obs_w[rd_ptr+i], exp_w[i]); end
        end
        rd_ptr = obs_n;
        exp_w.delete();
        $display("%s: chk=%02h status=%06b words=%0d", name, chk, st_a, words_a);
    endtask

    task automatic test_preamble();
        logic [7:0] junk [3];
        junk = '{8'h00, 8'hFF, 8'h5A};
        random_payload(4);
        model_writes(4);
        pulse_start();
        foreach (junk[j]) begin
            send_byte(junk[j]);
            n_cmp++;
            if (rx_ready_a !== 1'b1) begin n_fail++; $display("FAIL preamble_ready[%0d]: %b, required 1", j, rx_ready_a); end
        end
        n_cmp++;
        if (obs_n !== rd_ptr) begin n_fail++; $display("FAIL preamble_nowrite: %0d writes, required 0", obs_n - rd_ptr); end
        send_frame(good_chk(), 1);
        n_cmp++;
        if (st_a !== ST_OK) begin n_fail++; $display("FAIL preamble_status: %06b, required %06b", st_a, ST_OK); end
        n_cmp++;
        if (obs_n - rd_ptr !== int'(exp_w.size())) begin n_fail++; $display("FAIL preamble_nwrites: %0d, required %0d", obs_n - rd_ptr, exp_w.size()); end
        foreach (exp_w[i]) begin
            n_cmp++;
            if (obs_w[rd_ptr+i] !== exp_w[i]) begin n_fail++; $display("FAIL preamble_write[%0d]: %09h, required %09h", i, obs_w[rd_ptr+i], exp_w[i]); end
        end
        rd_ptr = obs_n;
        exp_w.delete();
        $display("preamble: status=%06b words=%0d", st_a, words_a);
    endtask

    task automatic test_timeout();
        pulse_start();
        send_byte(8'hA5);
        send_byte(8'h05);
        tick(1023);
        n_cmp++;
        if (st_a !== ST_BUSY) begin n_fail++; $display("FAIL timeout_early: status %06b after 1023 idle, required %06b", st_a, ST_BUSY); end
        tick(1);
        n_cmp += 3;
        if (st_a !== ST_TIMEOUT) begin n_fail++; $display("FAIL timeout_status_a: %06b, required %06b", st_a, ST_TIMEOUT); end
        if (st_b !== ST_TIMEOUT) begin n_fail++; $display("FAIL timeout_status_b: %06b, required %06b", st_b, ST_TIMEOUT); end
        if (obs_n !== rd_ptr) begin n_fail++; $display("FAIL timeout_nowrite: %0d writes, required 0", obs_n - rd_ptr); end
        rd_ptr = obs_n;
        $display("timeout: status=%06b words=%0d", st_a, words_a);
    endtask

    task automatic test_timeout_edge();
        random_payload(2);
        model_writes(2);
        pulse_start();
        send_byte(8'hA5);
        send_byte(8'h02);
        tick(1023);
        send_byte(pay_q[0]);
        send_byte(pay_q[1]);
        tick(1023);
        send_byte(good_chk());
        n_cmp += 2;
        if (st_a !== ST_OK) begin n_fail++; $display("FAIL timeout_edge_status: %06b, required %06b", st_a, ST_OK); end
        if (words_a !== 9'd2) begin n_fail++; $display("FAIL timeout_edge_words: %0d, required 2", words_a); end
        n_cmp++;
        if (obs_n - rd_ptr !== int'(exp_w.size())) begin n_fail++; $display("FAIL timeout_edge_nwrites: %0d, required %0d", obs_n - rd_ptr, exp_w.size()); end
        foreach (exp_w[i]) begin
            n_cmp++;
            if (obs_w[rd_ptr+i] !== exp_w[i]) begin n_fail++; $display("FAIL timeout_edge_write[%0d]: %09h, required %09h", i, obs_w[rd_ptr+i], exp_w[i]); end
        end
        rd_ptr = obs_n;
        exp_w.delete();
        $display("timeout_edge: status=%06b words=%0d", st_a, words_a);
    endtask

    task automatic test_back_to_back();
        int span;
        random_payload(256);
        model_writes(256);
        pulse_start();
        send_byte(8'hA5);
        send_byte(8'h00);
        foreach (pay_q[i]) begin
            if (i == 100) start = 1'b1;
            send_byte(pay_q[i]);
            start = 1'b0;
        end
        send_byte(good_chk());
        n_cmp += 3;
        if (st_a !== ST_OK) begin n_fail++; $display("FAIL b2b_status: %06b, required %06b", st_a, ST_OK); end
        if (words_a !== 9'd256) begin n_fail++; $display("FAIL b2b_words_a: %0d, required 256", words_a); end
        if (words_b !== 9'd256) begin n_fail++; $display("FAIL b2b_words_b: %0d, required 256", words_b); end
        n_cmp++;
        if (obs_n - rd_ptr !== int'(exp_w.size())) begin n_fail++; $display("FAIL b2b_nwrites: %0d, required %0d", obs_n - rd_ptr, exp_w.size()); end
        foreach (exp_w[i]) begin
            n_cmp++;
            if (obs_w[rd_ptr+i] !== exp_w[i]) begin n_fail++; $display("FAIL b2b_write[%0d]: %09h, required %09h", i, obs_w[rd_ptr+i], exp_w[i]); end
        end
        span = obs_cyc[obs_n-1] - obs_cyc[rd_ptr];
        n_cmp++;
        if (span !== 255) begin n_fail++; $display("FAIL b2b_span: writes span %0d cycles, required 255", span); end
        rd_ptr = obs_n;
        exp_w.delete();
        $display("back_to_back: status=%06b words=%0d span=%0d", st_a, words_a, span);
    endtask

    task automatic test_random();
        logic [7:0] chk, b;
        logic [5:0] want;
        for (int f = 0; f < 20; f++) begin
            random_payload(int'($urandom_range(1, 24)));
            model_writes(pay_q.size());
            chk = good_chk();
            if ($urandom_range(0, 1) == 1) chk = chk ^ 8'($urandom_range(1, 255));
            want = exp_status(chk);
            pulse_start();
            repeat ($urandom_range(0, 2)) begin
                b = 8'($urandom);
                if (b == 8'hA5) b = 8'h00;
                send_byte(b);
            end
            send_frame(chk, 3);
            n_cmp += 3;
            if (st_a !== want) begin n_fail++; $display("FAIL rand%0d_status_a: %06b, required %06b", f, st_a, want); end
            if (st_b !== want) begin n_fail++; $display("FAIL rand%0d_status_b: %06b, required %06b", f, st_b, want); end
            if (words_a !== 9'(pay_q.size())) begin n_fail++; $display("FAIL rand%0d_words: %0d, required %0d", f, words_a, pay_q.size()); end
            n_cmp++;
            if (obs_n - rd_ptr !== int'(exp_w.size())) begin n_fail++; $display("FAIL rand%0d_nwrites: %0d, required %0d", f, obs_n - rd_ptr, exp_w.size()); end
            foreach (exp_w[i]) begin
                n_cmp++;
                if (obs_w[rd_ptr+i] !== exp_w[i]) begin n_fail++; $display("FAIL rand%0d_write[%0d]: %09h, required %09h", f, i, obs_w[rd_ptr+i], exp_w[i]); end
            end
            rd_ptr = obs_n;
            exp_w.delete();
            $display("random[%0d]: len=%0d chk=%02h status=%06b", f, pay_q.size(), chk, st_a);
        end
    endtask

    task automatic test_reset_mid();
        random_payload(5);
        model_writes(2);
        pulse_start();
        send_byte(8'hA5);
        send_byte(8'h05);
        send_byte(pay_q[0]);
        send_byte(pay_q[1]);
        reset = 1'b1;
        tick(1);
        n_cmp += 2;
        if (out_a !== 33'd0) begin n_fail++; $display("FAIL reset_mid_a: outputs %09h, required 0", out_a); end
        if (out_b !== 33'd0) begin n_fail++; $display("FAIL reset_mid_b: outputs %09h, required 0", out_b); end
        reset = 1'b0;
        tick(2);
        n_cmp++;
        if (obs_n - rd_ptr !== int'(exp_w.size())) begin n_fail++; $display("FAIL reset_mid_nwrites: %0d, required %0d", obs_n - rd_ptr, exp_w.size()); end
        foreach (exp_w[i]) begin
            n_cmp++;
            if (obs_w[rd_ptr+i] !== exp_w[i]) begin n_fail++; $display("FAIL reset_mid_write[%0d]: %09h, required %09h", i, obs_w[rd_ptr+i], exp_w[i]); end
        end
        rd_ptr = obs_n;
        exp_w.delete();
        $display("reset_mid: outputs a=%09h b=%09h", out_a, out_b);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1, "global timeout");
    end

    initial begin
        test_reset();
        test_frame_fixed("good_frame", 8'h36);
        test_frame_fixed("bad_checksum", 8'h37);
        test_preamble();
        test_timeout();
        test_timeout_edge();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
